// File: rtl/burst_ecc_serial_rx_if.sv
// Serial link input and queued codeword output of the burst-ECC receiver.
// The master drives the link bits and out_ready; the slave (receiver) returns queued entries.
interface burst_ecc_serial_rx_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SYN_WIDTH  = 8
);
  logic                  rx_bit;
  logic                  rx_bit_valid;
  logic                  rx_frame_start;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_error;
  logic [SYN_WIDTH-1:0]  out_syndrome;

  modport master (
    output rx_bit, rx_bit_valid, rx_frame_start, out_ready,
    input  out_valid, out_data, out_error, out_syndrome
  );

  modport slave (
    input  rx_bit, rx_bit_valid, rx_frame_start, out_ready,
    output out_valid, out_data, out_error, out_syndrome
  );
endinterface

// File: rtl/burst_ecc_serial_rx.sv
// Burst-ECC link receiver: deserialises LSB-first 16-bit codewords, checks parity,
// queues {error, syndrome, data} toward the consumer and keeps saturating link statistics.
module burst_ecc_serial_rx #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned CODEWORD_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  burst_ecc_serial_rx_if.slave bus,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic [CNT_WIDTH-1:0] drop_count,
  output logic [CNT_WIDTH-1:0] frame_err_count,
  output logic                 overflow
);

  localparam int unsigned PAR_WIDTH   = CODEWORD_WIDTH - DATA_WIDTH;
  localparam int unsigned ENTRY_WIDTH = 1 + PAR_WIDTH + DATA_WIDTH;
  localparam int unsigned PTR_WIDTH   = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_WIDTH   = PTR_WIDTH + 1;
  localparam int unsigned BIT_WIDTH   = $clog2(CODEWORD_WIDTH);

  localparam logic [BIT_WIDTH-1:0] LAST_BIT = BIT_WIDTH'(CODEWORD_WIDTH - 1);
  localparam logic [OCC_WIDTH-1:0] OCC_FULL = OCC_WIDTH'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_CHECK = 2'd2
  } state_e;

  state_e                   state_q;
  logic [CODEWORD_WIDTH-1:0] cw_q;
  logic [BIT_WIDTH-1:0]     bit_cnt_q;

  logic [ENTRY_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]     wr_ptr_q;
  logic [PTR_WIDTH-1:0]     rd_ptr_q;
  logic [OCC_WIDTH-1:0]     occ_q;
  logic [OCC_WIDTH-1:0]     occ_d;
  logic                     valid_q;

  logic [CNT_WIDTH-1:0]     err_cnt_q;
  logic [CNT_WIDTH-1:0]     drop_cnt_q;
  logic [CNT_WIDTH-1:0]     ferr_cnt_q;
  logic                     overflow_q;

  logic [2:0]               grp_c;
  logic [PAR_WIDTH-1:0]     syn_c;
  logic                     syn_err_c;
  logic                     start_bit_c;
  logic                     data_bit_c;
  logic                     push_c;
  logic                     pop_c;
  logic                     full_c;
  logic                     push_ok_c;

  // Parity groups over the data byte; parity bit i is covered by group (i mod 3).
  assign grp_c[0] = cw_q[1] ^ cw_q[4] ^ cw_q[7];
  assign grp_c[1] = cw_q[0] ^ cw_q[3] ^ cw_q[6];
  assign grp_c[2] = cw_q[2] ^ cw_q[5];

  for (genvar i = 0; i < PAR_WIDTH; i++) begin : g_syn
    assign syn_c[i] = cw_q[DATA_WIDTH + i] ^ grp_c[i % 3];
  end

  assign syn_err_c   = |syn_c;
  assign start_bit_c = bus.rx_bit_valid & bus.rx_frame_start;
  assign data_bit_c  = bus.rx_bit_valid & ~bus.rx_frame_start;

  assign push_c    = (state_q == S_CHECK);
  assign pop_c     = valid_q & bus.out_ready;
  assign full_c    = (occ_q == OCC_FULL);
  assign push_ok_c = push_c & (~full_c | pop_c);

  always_comb begin
    occ_d = occ_q;
    case ({push_ok_c, pop_c})
      2'b10:   occ_d = occ_q + OCC_WIDTH'(1);
      2'b01:   occ_d = occ_q - OCC_WIDTH'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Frame assembly FSM: bit 0 is always taken on frame_start, even mid-frame or in CHECK.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cw_q       <= '0;
      bit_cnt_q  <= '0;
      ferr_cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_bit_c) begin
            cw_q[0]   <= bus.rx_bit;
            bit_cnt_q <= BIT_WIDTH'(1);
            state_q   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (start_bit_c) begin
            cw_q[0]   <= bus.rx_bit;
            bit_cnt_q <= BIT_WIDTH'(1);
            if (ferr_cnt_q != '1) ferr_cnt_q <= ferr_cnt_q + CNT_WIDTH'(1);
          end else if (data_bit_c) begin
            cw_q[bit_cnt_q] <= bus.rx_bit;
            bit_cnt_q       <= bit_cnt_q + BIT_WIDTH'(1);
            if (bit_cnt_q == LAST_BIT) state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (start_bit_c) begin
            cw_q[0]   <= bus.rx_bit;
            bit_cnt_q <= BIT_WIDTH'(1);
            state_q   <= S_SHIFT;
          end else begin
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Output queue; a full queue still accepts a push when the head leaves in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (push_ok_c) begin
        mem_q[wr_ptr_q] <= {syn_err_c, syn_c, cw_q[DATA_WIDTH-1:0]};
        wr_ptr_q        <= wr_ptr_q + PTR_WIDTH'(1);
      end
      if (pop_c) rd_ptr_q <= rd_ptr_q + PTR_WIDTH'(1);
      occ_q   <= occ_d;
      valid_q <= (occ_d != '0);
    end
  end

  // Link statistics; dropped entries still count toward err_count.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q  <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else if (push_c) begin
      if (syn_err_c && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + CNT_WIDTH'(1);
      if (!push_ok_c) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.out_valid = valid_q;
  assign {bus.out_error, bus.out_syndrome, bus.out_data} = mem_q[rd_ptr_q];

  assign err_count       = err_cnt_q;
  assign drop_count      = drop_cnt_q;
  assign frame_err_count = ferr_cnt_q;
  assign overflow        = overflow_q;

endmodule

// File: tb/tb_burst_ecc_serial_rx.sv
// Randomised bench for burst_ecc_serial_rx against a queue-based reference model,
// plus directed scenarios for the documented examples and counter saturation.
module tb_burst_ecc_serial_rx;

  localparam int DEPTH = 4;
  localparam int CMAX  = 255;

  logic       clk;
  logic       rst;
  logic [7:0] err_count;
  logic [7:0] drop_count;
  logic [7:0] frame_err_count;
  logic       overflow;

  burst_ecc_serial_rx_if #(.DATA_WIDTH(8), .SYN_WIDTH(8)) ifc ();

  burst_ecc_serial_rx #(
    .DATA_WIDTH(8), .CODEWORD_WIDTH(16), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (ifc),
    .err_count       (err_count),
    .drop_count      (drop_count),
    .frame_err_count (frame_err_count),
    .overflow        (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [16:0] mq[$];        // {error, syndrome, data} expected at the head
  logic [15:0] m_cw;
  logic [15:0] m_done;
  int          m_n;
  bit          m_pending;
  int          m_err, m_drop, m_ferr;
  bit          m_ovf;

  bit          tb_ready;
  bit          rand_ready;
  int          dut_pops;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_par(input logic [7:0] d);
    logic [2:0] g;
    logic [7:0] p;
    g[0] = ^(d & 8'h92);
    g[1] = ^(d & 8'h49);
    g[2] = ^(d & 8'h24);
    for (int i = 0; i < 8; i++) p[i] = g[i % 3];
    return p;
  endfunction

  function automatic logic [15:0] make_cw(input logic [7:0] d);
    return {ref_par(d), d};
  endfunction

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic compare_all();
    check_eq("out_valid", 32'(ifc.out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      check_eq("out_data",     32'(ifc.out_data),     32'(mq[0][7:0]));
      check_eq("out_syndrome", 32'(ifc.out_syndrome), 32'(mq[0][15:8]));
      check_eq("out_error",    32'(ifc.out_error),    32'(mq[0][16]));
    end
    check_eq("err_count",       32'(err_count),       32'(m_err));
    check_eq("drop_count",      32'(drop_count),      32'(m_drop));
    check_eq("frame_err_count", 32'(frame_err_count), 32'(m_ferr));
    check_eq("overflow",        32'(overflow),        32'(m_ovf));
  endtask

  // One clock cycle: drive inputs, advance the model, then compare after the edge.
  task automatic tick(input logic b, input logic v, input logic f);
    bit         pop;
    bit         ok;
    logic [7:0] syn;
    if (rand_ready) tb_ready = ($urandom_range(0, 2) != 0);
    ifc.rx_bit         = b;
    ifc.rx_bit_valid   = v;
    ifc.rx_frame_start = f;
    ifc.out_ready      = tb_ready;
    if (ifc.out_valid && tb_ready) dut_pops++;

    pop = (mq.size() != 0) && tb_ready;
    ok  = 1'b0;
    syn = 8'h00;
    if (m_pending) begin
      syn = m_done[15:8] ^ ref_par(m_done[7:0]);
      if (syn != 8'h00) m_err = sat(m_err);
      ok = (mq.size() < DEPTH) || pop;
      if (!ok) begin
        m_drop = sat(m_drop);
        m_ovf  = 1'b1;
      end
    end
    if (pop) void'(mq.pop_front());
    if (m_pending && ok) mq.push_back({|syn, syn, m_done[7:0]});
    m_pending = 1'b0;

    if (v) begin
      if (f) begin
        if (m_n > 0) m_ferr = sat(m_ferr);
        m_cw    = 16'h0000;
        m_cw[0] = b;
        m_n     = 1;
      end else if (m_n > 0) begin
        m_cw[m_n] = b;
        m_n++;
        if (m_n == 16) begin
          m_done    = m_cw;
          m_pending = 1'b1;
          m_n       = 0;
        end
      end
    end

    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic send_frame(input logic [15:0] cw);
    for (int i = 0; i < 16; i++) tick(cw[i], 1'b1, i == 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    ifc.rx_bit         = 1'b0;
    ifc.rx_bit_valid   = 1'b0;
    ifc.rx_frame_start = 1'b0;
    ifc.out_ready      = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    m_n = 0; m_pending = 1'b0; m_cw = '0; m_done = '0;
    m_err = 0; m_drop = 0; m_ferr = 0; m_ovf = 1'b0;
    dut_pops = 0;
    tb_ready = 1'b0;
    rand_ready = 1'b0;
    check_eq("rst_out_data",     32'(ifc.out_data),     32'h0);
    check_eq("rst_out_syndrome", 32'(ifc.out_syndrome), 32'h0);
    check_eq("rst_out_error",    32'(ifc.out_error),    32'h0);
    compare_all();
  endtask

  initial begin
    logic [15:0] cw;
    int          mode;
    rst = 1'b1;
    @(negedge clk);

    // Clean codeword with documented latency
    do_reset();
    send_frame(16'hDBA5);
    check_eq("t1_valid_T+1", 32'(ifc.out_valid), 32'h0);
    idle(1);
    check_eq("t1_valid_T+2", 32'(ifc.out_valid),    32'h1);
    check_eq("t1_data",      32'(ifc.out_data),     32'hA5);
    check_eq("t1_syndrome",  32'(ifc.out_syndrome), 32'h00);
    check_eq("t1_error",     32'(ifc.out_error),    32'h0);
    check_eq("t1_err_count", 32'(err_count),        32'h0);
    idle(2);
    check_eq("t1_held_data", 32'(ifc.out_data), 32'hA5);
    tb_ready = 1'b1;
    idle(1);
    tb_ready = 1'b0;

    // Single-bit error in data bit 0
    send_frame(16'hDBA4);
    idle(1);
    check_eq("t2_data",      32'(ifc.out_data),     32'hA4);
    check_eq("t2_syndrome",  32'(ifc.out_syndrome), 32'h92);
    check_eq("t2_error",     32'(ifc.out_error),    32'h1);
    check_eq("t2_err_count", 32'(err_count),        32'h1);

    // Overflow with a stalled consumer
    do_reset();
    for (int k = 0; k < 5; k++) send_frame(16'hDBA5);
    idle(1);
    check_eq("t3_drop_count", 32'(drop_count), 32'h1);
    check_eq("t3_overflow",   32'(overflow),   32'h1);
    dut_pops = 0;
    tb_ready = 1'b1;
    idle(8);
    check_eq("t3_pops",       32'(dut_pops),   32'h4);
    check_eq("t3_overflow_sticky", 32'(overflow), 32'h1);

    // Early frame_start aborts a partial frame
    do_reset();
    for (int i = 0; i < 7; i++) tick(1'($urandom_range(0, 1)), 1'b1, i == 0);
    send_frame(16'hDBA5);
    idle(1);
    check_eq("t4_frame_err", 32'(frame_err_count), 32'h1);
    check_eq("t4_data",      32'(ifc.out_data),    32'hA5);
    dut_pops = 0;
    tb_ready = 1'b1;
    idle(6);
    check_eq("t4_pops",      32'(dut_pops),        32'h1);

    // Reset in mid-frame discards the partial frame
    do_reset();
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, i == 0);
    do_reset();
    send_frame(16'hDBA5);
    idle(1);
    check_eq("t5_valid",     32'(ifc.out_valid),   32'h1);
    check_eq("t5_data",      32'(ifc.out_data),    32'hA5);
    check_eq("t5_err",       32'(err_count),       32'h0);
    check_eq("t5_drop",      32'(drop_count),      32'h0);
    check_eq("t5_frame_err", 32'(frame_err_count), 32'h0);

    // Back-to-back frames, next frame_start landing in the CHECK cycle
    do_reset();
    tb_ready = 1'b1;
    for (int k = 0; k < 6; k++) send_frame(make_cw(8'($urandom)));
    idle(3);
    check_eq("t6_pops", 32'(dut_pops),   32'h6);
    check_eq("t6_drop", 32'(drop_count), 32'h0);

    // Counter saturation with a stalled consumer and corrupted frames
    do_reset();
    for (int k = 0; k < 262; k++) send_frame(make_cw(8'($urandom)) ^ 16'h0001);
    idle(1);
    check_eq("sat_err",  32'(err_count),  32'(CMAX));
    check_eq("sat_drop", 32'(drop_count), 32'(CMAX));

    // Randomised traffic: good, corrupted and noisy frames with a random consumer
    do_reset();
    rand_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      mode = int'($urandom_range(0, 2));
      cw   = make_cw(8'($urandom));
      if (mode == 0) send_frame(cw);
      else if (mode == 1) send_frame(cw ^ (16'h0001 << $urandom_range(0, 15)));
      else begin
        for (int i = 0; i < 8; i++)
          tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 9) == 0));
      end
    end
    rand_ready = 1'b0;
    tb_ready   = 1'b1;
    idle(10);
    check_eq("drain_empty", 32'(ifc.out_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
